// File: rtl/cs_stream_ctrl.sv
// Sequencer for the CS sliding-window datapath: framing FSM, result tag pipeline and
// credit-protected first-word-fall-through result FIFO. Optional CS_STREAM_CTRL_STATS_EN adds frame/result counters.
module cs_stream_ctrl #(
  parameter int unsigned WIN        = 9,
  parameter int unsigned DP_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  output logic        dp_shift_o,
  output logic [7:0]  dp_x_o,
  output logic        dp_clr_o,
  input  logic [9:0]  dp_y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [9:0]  out_data_o,
  output logic        out_last_o,
  output logic        short_frame_o,
  output logic        busy_o
`ifdef CS_STREAM_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] result_cnt_o
`endif
);

  localparam int unsigned FCW = $clog2(WIN + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned TW  = CW + 1;

  typedef enum logic [1:0] {CLEAR, FILL, RUN, DRAIN} state_e;
  typedef struct packed {
    logic       last;
    logic [9:0] data;
  } res_t;

  state_e            state_q, state_d;
  logic [FCW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [7:0]        dp_x_q, dp_x_d;
  logic              dp_shift_q, dp_shift_d;
  logic              dp_clr_q, dp_clr_d;
  logic              iss_v_q, iss_v_d, iss_last_q, iss_last_d;
  logic [DP_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
  res_t              mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d, infl_d;
  res_t              head_q, head_d, push_entry;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              short_q, short_d;
  logic              busy_q, busy_d;
  logic              accept, push, pop, producing;

  // Tag pipeline and FIFO bookkeeping; the tag tail lines up with a valid dp_y
  always_comb begin
    accept     = in_valid_i & in_ready_q;
    push       = pv_q[DP_LAT-1];
    pop        = out_valid_q & out_ready_i;
    push_entry = '{last: pl_q[DP_LAT-1], data: dp_y_i};
    pv_d       = '0;
    pl_d       = '0;
    pv_d[0]    = iss_v_q;
    pl_d[0]    = iss_last_q;
    for (int unsigned i = 1; i < DP_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
    infl_d = '0;
    for (int unsigned i = 0; i < DP_LAT; i++) begin
      infl_d = infl_d + CW'(pv_d[i]);
    end
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    out_valid_d = (cnt_d != '0);
    head_d      = (push && (wr_ptr_q == rd_ptr_d)) ? push_entry : mem_q[rd_ptr_d];
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    short_d    = 1'b0;
    producing  = 1'b0;
    case (state_q)
      CLEAR: begin
        state_d    = FILL;
        fill_cnt_d = '0;
      end
      FILL: begin
        if (accept) begin
          if (fill_cnt_q == FCW'(WIN - 1)) begin
            producing  = 1'b1;
            fill_cnt_d = FCW'(WIN);
            state_d    = in_last_i ? DRAIN : RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + FCW'(1);
            if (in_last_i) begin
              short_d = 1'b1;
              state_d = CLEAR;
            end
          end
        end
      end
      RUN: begin
        if (accept) begin
          producing = 1'b1;
          if (in_last_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((cnt_d == '0) && (pv_d == '0)) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
    iss_v_d    = producing;
    iss_last_d = producing & in_last_i;
    dp_shift_d = accept;
    dp_x_d     = accept ? in_data_i : dp_x_q;
    dp_clr_d   = (state_d == CLEAR);
    // Credits cover every result already owed to the FIFO, including the one being issued
    in_ready_d = ((state_d == FILL) || (state_d == RUN)) &&
                 ((TW'(cnt_d) + TW'(infl_d) + TW'(iss_v_d)) < TW'(FIFO_DEPTH));
    busy_d     = !((state_d == FILL) && (fill_cnt_d == '0) && (cnt_d == '0) &&
                   (pv_d == '0) && !iss_v_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CLEAR;
      fill_cnt_q  <= '0;
      dp_x_q      <= '0;
      dp_shift_q  <= 1'b0;
      dp_clr_q    <= 1'b1;
      iss_v_q     <= 1'b0;
      iss_last_q  <= 1'b0;
      pv_q        <= '0;
      pl_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      short_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      dp_x_q      <= dp_x_d;
      dp_shift_q  <= dp_shift_d;
      dp_clr_q    <= dp_clr_d;
      iss_v_q     <= iss_v_d;
      iss_last_q  <= iss_last_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      if (push) mem_q[wr_ptr_q] <= push_entry;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      short_q     <= short_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign dp_shift_o    = dp_shift_q;
  assign dp_x_o        = dp_x_q;
  assign dp_clr_o      = dp_clr_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = head_q.data;
  assign out_last_o    = head_q.last;
  assign short_frame_o = short_q;
  assign busy_o        = busy_q;

`ifdef CS_STREAM_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, result_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q  <= '0;
      result_cnt_q <= '0;
    end else begin
      if (((state_q == DRAIN) && (state_d == CLEAR)) || short_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == CLEAR) result_cnt_q <= '0;
      else if (pop)         result_cnt_q <= result_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o  = frame_cnt_q;
  assign result_cnt_o = result_cnt_q;
`endif

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Directed bench for cs_stream_ctrl with a 9-tap window-sum datapath model (DP_LAT=1).
module tb_cs_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [7:0] in_data = 8'd0;
  logic       dp_shift, dp_clr;
  logic [7:0] dp_x;
  logic [9:0] dp_y = 10'd0;
  logic       out_valid, out_last, out_ready = 1'b1;
  logic [9:0] out_data;
  logic       short_frame, busy;
`ifdef CS_STREAM_CTRL_STATS_EN
  logic [15:0] frame_cnt, result_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int acc_n = 0, res_n = 0, clr_n = 0, sf_n = 0;
  int acc_cyc [512];
  int res_cyc [512];
  int res_data [512];
  int res_last [512];
  logic [7:0] win [8];
  logic [9:0] win_sum;

  cs_stream_ctrl #(.WIN(9), .DP_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
    .dp_shift_o(dp_shift), .dp_x_o(dp_x), .dp_clr_o(dp_clr), .dp_y_i(dp_y),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
    .short_frame_o(short_frame), .busy_o(busy)
`ifdef CS_STREAM_CTRL_STATS_EN
    , .frame_cnt_o(frame_cnt), .result_cnt_o(result_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: sum of the newest 9 samples, valid one cycle after dp_shift
  always_comb begin
    win_sum = 10'(dp_x);
    for (int i = 0; i < 8; i++) win_sum = win_sum + 10'(win[i]);
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 8; i++) win[i] <= 8'd0;
    end else if (dp_shift) begin
      win[0] <= dp_x;
      for (int i = 1; i < 8; i++) win[i] <= win[i-1];
      dp_y <= win_sum;
    end
  end

  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      acc_cyc[acc_n % 512] <= cyc;
      acc_n <= acc_n + 1;
    end
    if (out_valid && out_ready) begin
      res_cyc[res_n % 512]  <= cyc;
      res_data[res_n % 512] <= int'(out_data);
      res_last[res_n % 512] <= int'(out_last);
      res_n <= res_n + 1;
    end
    if (dp_clr) clr_n <= clr_n + 1;
    if (short_frame) sf_n <= sf_n + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int first, input int step, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(first + i * step);
      in_last  = with_last && (i == n - 1);
      while (!in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        check_eq("send_timeout", guard, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check_eq("idle_timeout", guard, 0);
    @(negedge clk);
  endtask

  task automatic check_ramp(input string tag, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s_data%0d", tag, k), res_data[base + k], 180 + 9 * k);
      check_eq($sformatf("%s_last%0d", tag, k), res_last[base + k], (k == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int rb, ab, sb, cb, guard;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_dp_clr", int'(dp_clr), 1);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_dp_shift", int'(dp_shift), 0);
    check_eq("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    #1;
    check_eq("clear_dp_clr", int'(dp_clr), 1);
    @(negedge clk);
    check_eq("fill_dp_clr", int'(dp_clr), 0);
    check_eq("fill_in_ready", int'(in_ready), 1);

    // 20-sample ramp frame, downstream always ready
    rb = res_n; ab = acc_n;
    send(8'h10, 1, 20, 1'b1);
    wait_idle();
    check_eq("t1_count", res_n - rb, 12);
    check_ramp("t1", rb, 12);
    check_eq("t1_latency", res_cyc[rb] - acc_cyc[ab + 8], 3);

    // Same frame with downstream stalled until credits run out
    rb = res_n; ab = acc_n;
    out_ready = 1'b0;
    fork
      send(8'h10, 1, 20, 1'b1);
      begin
        guard = 0;
        while ((acc_n - ab) < 12 && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        repeat (10) @(negedge clk);
        check_eq("t2_accepts", acc_n - ab, 12);
        check_eq("t2_in_ready", int'(in_ready), 0);
        check_eq("t2_out_valid", int'(out_valid), 1);
        check_eq("t2_head", int'(out_data), 180);
        check_eq("t2_head_last", int'(out_last), 0);
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check_eq("t2_count", res_n - rb, 12);
    check_ramp("t2", rb, 12);

    // Short frame, then a full frame restarts from an empty window
    rb = res_n; sb = sf_n;
    send(8'h50, 1, 5, 1'b1);
    @(negedge clk);
    check_eq("t3_short_pulse", int'(short_frame), 1);
    check_eq("t3_dp_clr", int'(dp_clr), 1);
    wait_idle();
    check_eq("t3_short_count", sf_n - sb, 1);
    check_eq("t3_no_results", res_n - rb, 0);
    send(2, 0, 9, 1'b1);
    wait_idle();
    check_eq("t3_refill_count", res_n - rb, 1);
    check_eq("t3_refill_data", res_data[rb], 18);
    check_eq("t3_refill_last", res_last[rb], 1);

    // Back-to-back frames of 9 and 10 samples
    rb = res_n; cb = clr_n;
    send(1, 0, 9, 1'b1);
    send(8'h20, 1, 10, 1'b1);
    wait_idle();
    check_eq("t4_count", res_n - rb, 3);
    check_eq("t4_f1_data", res_data[rb], 9);
    check_eq("t4_f1_last", res_last[rb], 1);
    check_eq("t4_f2_data0", res_data[rb + 1], 324);
    check_eq("t4_f2_last0", res_last[rb + 1], 0);
    check_eq("t4_f2_data1", res_data[rb + 2], 333);
    check_eq("t4_f2_last1", res_last[rb + 2], 1);
    check_eq("t4_clr_cycles", clr_n - cb, 2);

    // Reset in RUN with three results queued
    out_ready = 1'b0;
    send(8'h30, 1, 11, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("t5_queued_valid", int'(out_valid), 1);
    check_eq("t5_credit_left", int'(in_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_valid", int'(out_valid), 0);
    check_eq("t5_async_clr", int'(dp_clr), 1);
    check_eq("t5_async_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_post_valid", int'(out_valid), 0);
    rb = res_n;
    send(3, 0, 9, 1'b1);
    wait_idle();
    check_eq("t5_after_count", res_n - rb, 1);
    check_eq("t5_after_data", res_data[rb], 27);

`ifdef CS_STREAM_CTRL_STATS_EN
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1, 0, 9, 1'b1);
    send(5, 0, 4, 1'b1);
    send(7, 0, 12, 1'b1);
    guard = 0;
    while (!dp_clr && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("st_wait", int'(dp_clr), 1);
    check_eq("st_frame_cnt", int'(frame_cnt), 3);
    check_eq("st_result_cnt", int'(result_cnt), 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
